exp4_trena_uc: RTL and testbench

- Control unit for the trena (ultrasonic tape-measure) datapath.
- On a measure request it:
  - triggers one HC-SR04 measurement through the datapath;
  - waits for it to finish, or times out;
  - sequences the 7E1 serial transmitter through the 4-character frame: 3 digit characters, then the terminator, stepping the datapath's 2-bit character counter.
- Sits beside the datapath in the trena top level. Its Moore outputs drive the datapath control inputs directly.

---
 rtl/exp4_trena_uc.sv | 107 ++++++++++
 tb/tb_exp4_trena_uc.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/exp4_trena_uc.sv
`default_nettype none
// ============================================================================
// exp4_trena_uc : trena control unit - one HC-SR04 measurement, then a
//                 4-character 7E1 serial frame through the datapath.
// Revision      : 1.0
// ============================================================================
module exp4_trena_uc #(
  parameter int TIMEOUT_CICLOS = 1500000,
  parameter int TW             = 21
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mensurar,
  input  logic       pronto_medida,
  input  logic       pronto_transmissao,
  input  logic       fim_serial,
  output logic       medir,
  output logic       zera,
  output logic       conta_ascii,
  output logic       partida_serial,
  output logic       pronto,
  output logic       erro,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL       = 4'h0,
    PREPARA       = 4'h1,
    MEDE          = 4'h2,
    ESPERA_MEDIDA = 4'h3,
    TRANSMITE     = 4'h4,
    ESPERA_TX     = 4'h5,
    PROXIMO       = 4'h6,
    FINAL         = 4'h7,
    ERRO          = 4'hE
  } state_t;

  localparam logic [TW-1:0] c_timeout_tc = TW'(TIMEOUT_CICLOS - 1);

  state_t          state_q, state_d;
  logic   [TW-1:0] tmo_q, tmo_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= INICIAL;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d        = INICIAL;
    tmo_d          = tmo_q;
    medir          = 1'b0;
    zera           = 1'b0;
    conta_ascii    = 1'b0;
    partida_serial = 1'b0;
    pronto         = 1'b0;
    erro           = 1'b0;
    db_estado      = state_q;
    case (state_q)
      INICIAL: state_d = mensurar ? PREPARA : INICIAL;
      PREPARA: begin
        zera    = 1'b1;
        tmo_d   = '0;
        state_d = MEDE;
      end
      MEDE: begin
        medir   = 1'b1;
        state_d = ESPERA_MEDIDA;
      end
      ESPERA_MEDIDA: begin
        tmo_d = tmo_q + TW'(1);
        // An echo arriving on the terminal-count cycle still counts as a hit.
        if (pronto_medida)              state_d = TRANSMITE;
        else if (tmo_q == c_timeout_tc) state_d = ERRO;
        else                            state_d = ESPERA_MEDIDA;
      end
      TRANSMITE: begin
        partida_serial = 1'b1;
        state_d        = ESPERA_TX;
      end
      ESPERA_TX: state_d = pronto_transmissao ? PROXIMO : ESPERA_TX;
      PROXIMO: begin
        // Advancing here keeps the character selector stable during TRANSMITE.
        conta_ascii = ~fim_serial;
        state_d     = fim_serial ? FINAL : TRANSMITE;
      end
      FINAL: begin
        pronto  = 1'b1;
        state_d = mensurar ? PREPARA : INICIAL;
      end
      ERRO: begin
        erro    = 1'b1;
        state_d = mensurar ? PREPARA : ERRO;
      end
      default: begin
        db_estado = 4'h0;
        state_d   = INICIAL;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_exp4_trena_uc.sv
`default_nettype none
// ============================================================================
// tb_exp4_trena_uc : randomized bench for the trena control unit with a
//                    datapath responder and cycle-arithmetic frame model.
// Revision         : 1.0
// ============================================================================
module tb_exp4_trena_uc;

  localparam int TO = 20;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       mensurar = 1'b0;
  logic       pronto_medida, pronto_transmissao, fim_serial;
  logic       medir, zera, conta_ascii, partida_serial, pronto, erro;
  logic [3:0] db_estado;

  exp4_trena_uc #(.TIMEOUT_CICLOS(TO), .TW(5)) dut (
    .clock(clock), .reset(reset), .mensurar(mensurar),
    .pronto_medida(pronto_medida), .pronto_transmissao(pronto_transmissao),
    .fim_serial(fim_serial), .medir(medir), .zera(zera),
    .conta_ascii(conta_ascii), .partida_serial(partida_serial),
    .pronto(pronto), .erro(erro), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Datapath character counter as the control unit sees it.
  logic [1:0] sel = 2'd0;
  always @(posedge clock) begin
    if (zera)             sel <= 2'd0;
    else if (conta_ascii) sel <= sel + 2'd1;
  end
  assign fim_serial = (sel == 2'd3);

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  int zera_n, medir_n, part_n, conta_n, pronto_n, erro_n;
  int medir_cyc = -10000;
  int pt_due    = -1;
  int pronto_cyc, erro_cyc;
  int d_val     = 1000;
  int e_tab [4];

  // Responder: samples outputs mid-cycle and answers with done pulses.
  initial begin
    pronto_medida      = 1'b0;
    pronto_transmissao = 1'b0;
    forever begin
      @(negedge clock);
      if (zera) zera_n++;
      if (medir) begin medir_n++; medir_cyc = cyc; end
      if (partida_serial) begin
        chk("char_sel", int'(sel), part_n % 4);
        pt_due = cyc + e_tab[part_n % 4];
        part_n++;
      end
      if (conta_ascii) conta_n++;
      if (pronto) begin pronto_n++; pronto_cyc = cyc; end
      if (erro) begin
        if (erro_n == 0) erro_cyc = cyc;
        erro_n++;
      end
      pronto_medida      = (cyc == medir_cyc + d_val);
      pronto_transmissao = (cyc == pt_due);
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic clear_counts();
    zera_n = 0; medir_n = 0; part_n = 0; conta_n = 0; pronto_n = 0; erro_n = 0;
  endtask

  function automatic int out_vec();
    return int'({medir, zera, conta_ascii, partida_serial, pronto, erro, db_estado});
  endfunction

  // One measurement: echo after d cycles; success iff d fits inside the window.
  task automatic frame(input int d, input int e_fix, input bit busy,
                       input bit chain, input bit started);
    int  guard;
    int  exp_pronto;
    bit  ok;
    bit  b;
    ok    = (d <= TO);
    b     = busy;
    d_val = d;
    for (int i = 0; i < 4; i++)
      e_tab[i] = (e_fix != 0) ? e_fix : int'($urandom_range(1, 15));
    if (!started) begin
      clear_counts();
      mensurar = 1'b1;
      tick();
      mensurar = 1'b0;
    end
    chk("prepara_state", int'(db_estado), 1);
    chk("prepara_zera", int'(zera), 1);
    chk("prepara_erro_clr", int'(erro), 0);
    tick();
    chk("mede_state", int'(db_estado), 2);
    chk("mede_medir", int'(medir), 1);
    guard = 0;
    while (!(pronto || erro) && guard < 3000) begin
      tick();
      guard++;
      if (b && db_estado == 4'h5 && part_n == 2) begin
        mensurar = 1'b1;
        tick();
        chk("busy_ignored", int'(db_estado), 5);
        mensurar = 1'b0;
        b = 1'b0;
      end
      if (chain && part_n == 4 && db_estado == 4'h5) mensurar = 1'b1;
    end
    chk("done_in_budget", int'(guard < 3000), 1);
    if (ok) begin
      exp_pronto = medir_cyc + d + 1;
      for (int i = 0; i < 4; i++) exp_pronto += e_tab[i] + 2;
      chk("pronto_seen", int'(pronto), 1);
      chk("pronto_cycle", pronto_cyc, exp_pronto);
      chk("medir_count", medir_n, 1);
      chk("zera_count", zera_n, 1);
      chk("char_count", part_n, 4);
      chk("conta_count", conta_n, 3);
      chk("erro_count", erro_n, 0);
      if (chain) begin
        clear_counts();
        tick();
        mensurar = 1'b0;
        chk("chain_pronto_1cyc", int'(pronto), 0);
        chk("chain_prepara", int'(db_estado), 1);
      end else begin
        tick();
        chk("pronto_1cyc", int'(pronto), 0);
        chk("back_to_idle", int'(db_estado), 0);
      end
    end else begin
      chk("erro_state", int'(db_estado), 'hE);
      chk("erro_out", int'(erro), 1);
      chk("erro_cycle", erro_cyc, medir_cyc + 1 + TO);
      chk("no_chars_on_timeout", part_n, 0);
      repeat (6) tick();
      chk("erro_held", int'(erro), 1);
      chk("erro_state_held", int'(db_estado), 'hE);
    end
  endtask

  initial begin
    int guard;
    clear_counts();
    for (int i = 0; i < 4; i++) e_tab[i] = 12;

    repeat (3) begin
      tick();
      chk("in_reset_outputs", out_vec(), 0);
    end
    reset = 1'b1;
    repeat (5) begin
      tick();
      chk("idle_outputs", out_vec(), 0);
    end

    frame(8, 12, 1'b0, 1'b0, 1'b0);     // nominal frame
    frame(1000, 12, 1'b0, 1'b0, 1'b0);  // no echo at all
    frame(TO, 12, 1'b0, 1'b0, 1'b0);    // echo on terminal count, retried from ERRO
    frame(TO + 1, 5, 1'b0, 1'b0, 1'b0); // echo one cycle too late
    frame(1, 0, 1'b0, 1'b0, 1'b0);
    frame(8, 12, 1'b1, 1'b0, 1'b0);     // request while busy
    frame(8, 12, 1'b0, 1'b1, 1'b0);     // request held through FINAL
    frame(6, 0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset while waiting on the second character.
    clear_counts();
    d_val = 5;
    for (int i = 0; i < 4; i++) e_tab[i] = 12;
    mensurar = 1'b1;
    tick();
    mensurar = 1'b0;
    guard = 0;
    while (!(part_n == 2 && db_estado == 4'h5) && guard < 500) begin
      tick();
      guard++;
    end
    chk("reach_second_char", int'(guard < 500), 1);
    reset = 1'b0;
    #1;
    chk("async_reset_outputs", out_vec(), 0);
    pt_due = -1;
    tick();
    tick();
    chk("held_reset_outputs", out_vec(), 0);
    reset = 1'b1;
    tick();
    frame(8, 12, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 6; k++)
      frame(int'($urandom_range(1, TO + 4)), 0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
